// File: rtl/fpu_issue_ctrl.sv
// FPU issue sequencer: accepts one decoded FP instruction, drives the FPU with stable
// control/operands and a one-cycle start pulse, waits for done (or times out), then
// presents the result on a writeback handshake. Owns fcsr (frm, fflags).
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  input  logic [31:0] in_op_c,
  output logic        fpu_start,
  output logic [6:0]  fpu_opcode,
  output logic [6:0]  fpu_func7,
  output logic [2:0]  fpu_func3,
  output logic [2:0]  fpu_frm,
  output logic [4:0]  fpu_rs2,
  output logic [31:0] fpu_operand_a,
  output logic [31:0] fpu_operand_b,
  output logic [31:0] fpu_operand_c,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_fflags,
  input  logic        fpu_done,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_to_int,
  output logic        wb_rd_we,
  output logic        wb_illegal,
  output logic        wb_timeout,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        busy
);

  localparam logic [TO_W-1:0] ToLast   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     CanonNan = 32'h7FC0_0000;
  localparam logic [4:0]      FlagNv   = 5'b10000;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic [2:0]      frm_snap_q, frm_snap_d;
  logic [2:0]      frm_q, frm_d;
  logic [4:0]      fflags_q, fflags_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [4:0]      wb_flags_q, wb_flags_d;
  logic            wb_illegal_q, wb_illegal_d;
  logic            wb_timeout_q, wb_timeout_d;

  logic [6:0] opcode, func7;
  logic [2:0] func3, eff_rm;
  logic       rm_op, illegal, wb_accept;
  logic       unused_bits;

  assign opcode = instr_q[6:0];
  assign func7  = instr_q[31:25];
  assign func3  = instr_q[14:12];
  assign eff_rm = (func3 == 3'b111) ? frm_snap_q : func3;

  // Rounding-mode consuming ops: fused multiply-add family, plus the OP-FP subset that rounds.
  always_comb begin
    rm_op = 1'b0;
    case (opcode)
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: rm_op = 1'b1;
      7'b1010011: rm_op = func7 inside {7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100,
                                        7'b0101100, 7'b1100000, 7'b1101000};
      default:    rm_op = 1'b0;
    endcase
  end

  assign illegal = rm_op && (eff_rm >= 3'd5);

  assign in_ready      = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign fpu_start     = (state_q == StIssue) && !illegal;
  assign fpu_opcode    = opcode;
  assign fpu_func7     = func7;
  assign fpu_func3     = func3;
  assign fpu_frm       = frm_snap_q;
  assign fpu_rs2       = instr_q[24:20];
  assign fpu_operand_a = op_a_q;
  assign fpu_operand_b = op_b_q;
  assign fpu_operand_c = op_c_q;

  assign wb_valid   = (state_q == StWb);
  assign wb_rd      = instr_q[11:7];
  assign wb_data    = wb_data_q;
  assign wb_to_int  = func7 inside {7'b1010000, 7'b1110000, 7'b1100000};
  assign wb_rd_we   = wb_valid && !wb_illegal_q;
  assign wb_illegal = wb_illegal_q;
  assign wb_timeout = wb_timeout_q;
  assign wb_accept  = wb_valid && wb_ready;

  // rs1 field and upper CSR write bits are not needed here.
  assign unused_bits = ^{instr_q[19:15], csr_wdata[31:8]};

  // Combinational fcsr read port.
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h001: csr_rdata = {27'b0, fflags_q};
      12'h002: csr_rdata = {29'b0, frm_q};
      12'h003: csr_rdata = {24'b0, frm_q, fflags_q};
      default: csr_rdata = 32'h0;
    endcase
  end

  // Sequencer next state, latched fields and writeback capture.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    frm_snap_d   = frm_snap_q;
    to_cnt_d     = to_cnt_q;
    wb_data_d    = wb_data_q;
    wb_flags_d   = wb_flags_q;
    wb_illegal_d = wb_illegal_q;
    wb_timeout_d = wb_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          instr_d      = in_instr;
          op_a_d       = in_op_a;
          op_b_d       = in_op_b;
          op_c_d       = in_op_c;
          frm_snap_d   = frm_q;
          wb_data_d    = 32'h0;
          wb_flags_d   = 5'h0;
          wb_illegal_d = 1'b0;
          wb_timeout_d = 1'b0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (illegal) begin
          wb_illegal_d = 1'b1;
          state_d      = StWb;
        end else begin
          to_cnt_d = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        // done in the timeout cycle still counts as a normal completion
        if (fpu_done) begin
          wb_data_d  = fpu_result;
          wb_flags_d = fpu_fflags;
          state_d    = StWb;
        end else if (to_cnt_q == ToLast) begin
          wb_data_d    = CanonNan;
          wb_flags_d   = FlagNv;
          wb_timeout_d = 1'b1;
          state_d      = StWb;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StWb: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // fcsr update: CSR write first, then OR in accrued flags so both take effect.
  always_comb begin
    fflags_d = fflags_q;
    frm_d    = frm_q;
    if (csr_we) begin
      case (csr_addr)
        12'h001: fflags_d = csr_wdata[4:0];
        12'h002: frm_d    = csr_wdata[2:0];
        12'h003: begin
          frm_d    = csr_wdata[7:5];
          fflags_d = csr_wdata[4:0];
        end
        default: ;
      endcase
    end
    if (wb_accept && !wb_illegal_q) fflags_d = fflags_d | wb_flags_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= 32'h0;
      op_a_q       <= 32'h0;
      op_b_q       <= 32'h0;
      op_c_q       <= 32'h0;
      frm_snap_q   <= 3'h0;
      frm_q        <= 3'h0;
      fflags_q     <= 5'h0;
      to_cnt_q     <= '0;
      wb_data_q    <= 32'h0;
      wb_flags_q   <= 5'h0;
      wb_illegal_q <= 1'b0;
      wb_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      frm_snap_q   <= frm_snap_d;
      frm_q        <= frm_d;
      fflags_q     <= fflags_d;
      to_cnt_q     <= to_cnt_d;
      wb_data_q    <= wb_data_d;
      wb_flags_q   <= wb_flags_d;
      wb_illegal_q <= wb_illegal_d;
      wb_timeout_q <= wb_timeout_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: scenario tasks against a behavioural fcsr/decode model.
module tb_fpu_issue_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_op_a, in_op_b, in_op_c;
  logic        fpu_start;
  logic [6:0]  fpu_opcode, fpu_func7;
  logic [2:0]  fpu_func3, fpu_frm;
  logic [4:0]  fpu_rs2;
  logic [31:0] fpu_operand_a, fpu_operand_b, fpu_operand_c;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_fflags;
  logic        fpu_done;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_to_int, wb_rd_we, wb_illegal, wb_timeout;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        busy;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_op_c(in_op_c),
    .fpu_start(fpu_start), .fpu_opcode(fpu_opcode), .fpu_func7(fpu_func7),
    .fpu_func3(fpu_func3), .fpu_frm(fpu_frm), .fpu_rs2(fpu_rs2),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_operand_c(fpu_operand_c), .fpu_result(fpu_result), .fpu_fflags(fpu_fflags),
    .fpu_done(fpu_done), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_to_int(wb_to_int), .wb_rd_we(wb_rd_we),
    .wb_illegal(wb_illegal), .wb_timeout(wb_timeout), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state
  logic [4:0] m_fflags = 5'h0;
  logic [2:0] m_frm    = 3'h0;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic bit m_rounds(input logic [31:0] ins);
    logic [6:0] opc;
    logic [6:0] f7;
    opc = ins[6:0];
    f7  = ins[31:25];
    if (opc inside {7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111}) return 1'b1;
    if (opc == 7'b1010011 && f7 inside {7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100,
                                        7'b0101100, 7'b1100000, 7'b1101000}) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_illegal(input logic [31:0] ins, input logic [2:0] frm);
    int rm;
    rm = (ins[14:12] == 3'b111) ? int'(frm) : int'(ins[14:12]);
    return m_rounds(ins) && (rm >= 5);
  endfunction

  function automatic bit m_to_int(input logic [31:0] ins);
    logic [6:0] f7;
    f7 = ins[31:25];
    return f7 inside {7'b1010000, 7'b1110000, 7'b1100000};
  endfunction

  function automatic void m_csr(input logic [11:0] addr, input logic [31:0] data);
    if (addr == 12'h001) m_fflags = data[4:0];
    else if (addr == 12'h002) m_frm = data[2:0];
    else if (addr == 12'h003) begin
      m_frm    = data[7:5];
      m_fflags = data[4:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
    tick();
    csr_we = 1'b0;
    m_csr(addr, data);
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [31:0] v);
    csr_addr = addr;
    #1;
    v = csr_rdata;
  endtask

  task automatic check_fcsr(input string name);
    logic [31:0] v;
    read_csr(12'h003, v);
    n_checks++;
    if (v !== {24'b0, m_frm, m_fflags}) begin
      n_errors++;
      $display("FAIL %s fcsr: got %h want %h", name, v, {24'b0, m_frm, m_fflags});
    end
  endtask

  // Full transaction: accept, FPU response after lat cycles (lat<0 = never), hold, handshake.
  task automatic run_op(input string name, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input int lat,
                        input logic [31:0] res, input logic [4:0] flg, input int hold,
                        input bit do_csr, input logic [11:0] caddr, input logic [31:0] cdata,
                        input bit stall_in);
    logic [2:0]  snap;
    bit          exp_ill;
    int          exp_cyc, cyc, n_start, start_cyc;
    logic [31:0] exp_data;
    logic [4:0]  exp_flags;
    logic [42:0] wb_snap;
    snap    = m_frm;
    exp_ill = m_illegal(instr, snap);
    if (exp_ill) begin
      exp_cyc = 2; exp_data = 32'h0; exp_flags = 5'h0;
    end else if (lat < 0) begin
      exp_cyc = 2 + TIMEOUT; exp_data = 32'h7FC00000; exp_flags = 5'b10000;
    end else begin
      exp_cyc = 2 + lat; exp_data = res; exp_flags = flg;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s in_ready_idle: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; in_instr = instr; in_op_a = a; in_op_b = b; in_op_c = c;
    tick();
    in_valid = 1'b0; in_instr = $urandom; in_op_a = $urandom; in_op_b = $urandom;
    in_op_c = $urandom;
    cyc = 1; n_start = 0; start_cyc = 0;
    while (wb_valid !== 1'b1 && cyc < TIMEOUT + 10) begin
      if (fpu_start === 1'b1) begin
        n_start++;
        start_cyc = cyc;
        n_checks++;
        if ({fpu_opcode, fpu_func7, fpu_func3, fpu_rs2, fpu_frm} !==
            {instr[6:0], instr[31:25], instr[14:12], instr[24:20], snap}) begin
          n_errors++;
          $display("FAIL %s fpu_ctrl: got %h want %h", name,
                   {fpu_opcode, fpu_func7, fpu_func3, fpu_rs2, fpu_frm},
                   {instr[6:0], instr[31:25], instr[14:12], instr[24:20], snap});
        end
        n_checks++;
        if ({fpu_operand_a, fpu_operand_b, fpu_operand_c} !== {a, b, c}) begin
          n_errors++;
          $display("FAIL %s fpu_operands: got %h want %h", name,
                   {fpu_operand_a, fpu_operand_b, fpu_operand_c}, {a, b, c});
        end
      end
      if (!exp_ill && lat > 0 && cyc == 1 + lat) begin
        fpu_done = 1'b1; fpu_result = res; fpu_fflags = flg;
      end else begin
        // A stray done in the issue cycle must be ignored.
        fpu_done = (cyc == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        fpu_result = $urandom; fpu_fflags = 5'($urandom);
      end
      tick();
      cyc++;
    end
    fpu_done = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b1 || cyc != exp_cyc) begin
      n_errors++;
      $display("FAIL %s wb_timing: got valid=%b cyc=%0d want valid=1 cyc=%0d", name,
               wb_valid, cyc, exp_cyc);
    end
    n_checks++;
    if (n_start != (exp_ill ? 0 : 1) || start_cyc != (exp_ill ? 0 : 1)) begin
      n_errors++;
      $display("FAIL %s start_pulse: got n=%0d at %0d want n=%0d at %0d", name, n_start,
               start_cyc, exp_ill ? 0 : 1, exp_ill ? 0 : 1);
    end
    n_checks++;
    if (wb_data !== exp_data) begin
      n_errors++;
      $display("FAIL %s wb_data: got %h want %h", name, wb_data, exp_data);
    end
    n_checks++;
    if ({wb_rd, wb_to_int, wb_rd_we, wb_illegal, wb_timeout} !==
        {instr[11:7], m_to_int(instr), !exp_ill, exp_ill, (!exp_ill && lat < 0)}) begin
      n_errors++;
      $display("FAIL %s wb_ctrl: got %b want %b", name,
               {wb_rd, wb_to_int, wb_rd_we, wb_illegal, wb_timeout},
               {instr[11:7], m_to_int(instr), !exp_ill, exp_ill, (!exp_ill && lat < 0)});
    end
    wb_snap = {wb_valid, wb_rd, wb_data, wb_to_int, wb_rd_we, wb_illegal, wb_timeout};
    for (int h = 0; h < hold; h++) begin
      in_valid = stall_in;
      fpu_done = 1'($urandom_range(0, 1)); fpu_result = $urandom; fpu_fflags = 5'($urandom);
      tick();
      n_checks++;
      if ({wb_valid, wb_rd, wb_data, wb_to_int, wb_rd_we, wb_illegal, wb_timeout} !== wb_snap
          || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s wb_hold: got %h rdy=%b want %h rdy=0", name,
                 {wb_valid, wb_rd, wb_data, wb_to_int, wb_rd_we, wb_illegal, wb_timeout},
                 in_ready, wb_snap);
      end
    end
    fpu_done = 1'b0;
    in_valid = stall_in;
    wb_ready = 1'b1;
    if (do_csr) begin
      csr_we = 1'b1; csr_addr = caddr; csr_wdata = cdata;
    end
    tick();
    wb_ready = 1'b0; csr_we = 1'b0;
    if (do_csr) m_csr(caddr, cdata);
    if (!exp_ill) m_fflags = m_fflags | exp_flags;
    n_checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s after_wb: got valid=%b rdy=%b busy=%b want 0 1 0", name, wb_valid,
               in_ready, busy);
    end
    in_valid = 1'b0;
    check_fcsr(name);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({busy, wb_valid, fpu_start, in_ready, wb_rd_we, wb_data, fpu_opcode} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 7'h0}) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b%b%b%b%b %h %h want 00010 0 0", busy, wb_valid,
               fpu_start, in_ready, wb_rd_we, wb_data, fpu_opcode);
    end
    rst_n = 1'b1;
    tick();
    read_csr(12'h003, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_fcsr: got %h want 0", v);
    end
  endtask

  task automatic test_csr();
    logic [31:0] v;
    csr_write(12'h003, 32'hFFFF_FFA5);
    read_csr(12'h001, v);
    n_checks++;
    if (v !== 32'h05) begin
      n_errors++;
      $display("FAIL csr_fflags: got %h want 05", v);
    end
    read_csr(12'h002, v);
    n_checks++;
    if (v !== 32'h05) begin
      n_errors++;
      $display("FAIL csr_frm: got %h want 05", v);
    end
    read_csr(12'h7FF, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_errors++;
      $display("FAIL csr_other: got %h want 0", v);
    end
    csr_write(12'h003, 32'h0);
    check_fcsr("csr_clear");
  endtask

  task automatic test_fadd();
    run_op("fadd", 32'h003100D3, 32'h3F800000, 32'h40000000, 32'h0, 3, 32'h40400000, 5'h0,
           0, 1'b0, 12'h0, 32'h0, 1'b0);
  endtask

  task automatic test_dyn_rm();
    logic [31:0] fmul;
    fmul = mk(7'b0001000, 5'd2, 5'd1, 3'b111, 5'd4, 7'b1010011);
    csr_write(12'h002, 32'h5);
    run_op("dyn_rm_bad", fmul, 32'h1, 32'h2, 32'h3, 2, 32'h1234, 5'h1f, 0, 1'b0, 12'h0, 32'h0,
           1'b0);
    csr_write(12'h002, 32'h1);
    run_op("dyn_rm_ok", fmul, 32'h40000000, 32'h40000000, 32'h0, 2, 32'h40800000, 5'h0, 0,
           1'b0, 12'h0, 32'h0, 1'b0);
  endtask

  task automatic test_flag_accrual();
    logic [31:0] fdiv;
    logic [31:0] v;
    fdiv = mk(7'b0001100, 5'd3, 5'd2, 3'b000, 5'd5, 7'b1010011);
    csr_write(12'h001, 32'h0);
    run_op("fdiv1", fdiv, 32'h3F800000, 32'h0, 32'h0, 4, 32'h7F800000, 5'b01000, 0, 1'b0,
           12'h0, 32'h0, 1'b0);
    read_csr(12'h001, v);
    n_checks++;
    if (v !== 32'h08) begin
      n_errors++;
      $display("FAIL accrue_1: got %h want 08", v);
    end
    run_op("fdiv2", fdiv, 32'h3F800000, 32'h40400000, 32'h0, 4, 32'h3EAAAAAB, 5'b00001, 0,
           1'b0, 12'h0, 32'h0, 1'b0);
    read_csr(12'h001, v);
    n_checks++;
    if (v !== 32'h09) begin
      n_errors++;
      $display("FAIL accrue_2: got %h want 09", v);
    end
    run_op("fdiv3", fdiv, 32'h3F800000, 32'h40400000, 32'h0, 4, 32'h3EAAAAAB, 5'b00001, 0,
           1'b1, 12'h001, 32'h0, 1'b0);
    read_csr(12'h001, v);
    n_checks++;
    if (v !== 32'h01) begin
      n_errors++;
      $display("FAIL accrue_csr_merge: got %h want 01", v);
    end
  endtask

  task automatic test_backpressure();
    run_op("backpressure", 32'h003100D3, 32'h1, 32'h2, 32'h3, 2, 32'hCAFEF00D, 5'h2, 5, 1'b0,
           12'h0, 32'h0, 1'b1);
    // A new instruction goes straight in one cycle after the handshake.
    run_op("back_to_back", mk(7'b1110000, 5'd0, 5'd7, 3'b000, 5'd9, 7'b1010011), 32'h5,
           32'h6, 32'h7, 1, 32'h00000001, 5'h0, 0, 1'b0, 12'h0, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    csr_write(12'h001, 32'h0);
    run_op("timeout", 32'h003100D3, 32'h1, 32'h2, 32'h3, -1, 32'h0, 5'h0, 1, 1'b0, 12'h0,
           32'h0, 1'b0);
    read_csr(12'h001, v);
    n_checks++;
    if (v !== 32'h10) begin
      n_errors++;
      $display("FAIL timeout_nv: got %h want 10", v);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs[5];
    logic [6:0] f7s[10];
    logic [31:0] ins;
    int lat;
    opcs = '{7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
    f7s  = '{7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100, 7'b0101100, 7'b1100000,
             7'b1101000, 7'b1010000, 7'b1110000, 7'b0010000};
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) csr_write(12'h002, $urandom);
      ins = mk(f7s[$urandom_range(0, 9)], 5'($urandom), 5'($urandom), 3'($urandom),
               5'($urandom), opcs[$urandom_range(0, 4)]);
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 6));
      run_op("random", ins, $urandom, $urandom, $urandom, lat, $urandom, 5'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] v;
    csr_write(12'h003, 32'hFF);
    in_valid = 1'b1; in_instr = 32'h003100D3; in_op_a = 32'h1; in_op_b = 32'h2;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    m_fflags = 5'h0; m_frm = 3'h0;
    read_csr(12'h003, v);
    n_checks++;
    if ({busy, wb_valid, fpu_start, v} !== {3'b000, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_wait_now: got busy=%b valid=%b start=%b fcsr=%h want 0 0 0 0",
               busy, wb_valid, fpu_start, v);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fpu_done = 1'b1; fpu_result = 32'hDEAD; fpu_fflags = 5'h1F;
      tick();
      n_checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL late_done: got valid=%b busy=%b want 0 0", wb_valid, busy);
      end
    end
    fpu_done = 1'b0;
    check_fcsr("reset_wait_fcsr");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_op_a = 32'h0; in_op_b = 32'h0;
    in_op_c = 32'h0; fpu_result = 32'h0; fpu_fflags = 5'h0; fpu_done = 1'b0;
    wb_ready = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    test_reset();
    test_csr();
    test_fadd();
    test_dyn_rm();
    test_flag_accrual();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequencer that sits directly upstream of the FPU top level. It accepts one decoded FP instruction and its operands from the core pipeline over a valid/ready handshake, then drives the FPU's control and data inputs stable, issues a one-cycle start pulse, and waits for done. It returns the result and accrued flags over a valid/ready writeback handshake. It also owns the fcsr register (frm, fflags) and its CSR access port.

Parameters:
TIMEOUT_CYCLES, 64, cycles to wait for fpu_done before forcing a timeout writeback.
TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  block can accept (high only in IDLE)
in_instr  in  32  raw instruction word
in_op_a  in  32  rs1 operand (FP or integer)
in_op_b  in  32  rs2 operand
in_op_c  in  32  rs3 operand
fpu_start  out  1  one-cycle start pulse to FPU
fpu_opcode  out  7  instr[6:0]
fpu_func7  out  7  instr[31:25]
fpu_func3  out  3  instr[14:12]
fpu_frm  out  3  frm snapshot taken at acceptance
fpu_rs2  out  5  instr[24:20]
fpu_operand_a / fpu_operand_b / fpu_operand_c  out  32 each  latched operands
fpu_result  in  32  FPU result
fpu_fflags  in  5  FPU flags {NV,DZ,OF,UF,NX}
fpu_done  in  1  FPU completion
wb_valid  out  1  writeback available
wb_ready  in  1  writeback consumed
wb_rd  out  5  instr[11:7]
wb_data  out  32  result
wb_to_int  out  1  1 = integer RF target (func7 1010000, 1110000 or 1100000); 0 = FP RF
wb_rd_we  out  1  0 for an illegal instruction
wb_illegal  out  1  illegal rounding mode
wb_timeout  out  1  FPU did not respond
csr_we  in  1  CSR write strobe
csr_addr  in  12  0x001 fflags, 0x002 frm, 0x003 fcsr
csr_wdata  in  32  write data
csr_rdata  out  32  combinational read; {27'b0,fflags} / {29'b0,frm} / {24'b0,frm,fflags}; 0 for other addresses
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all latched fields, fpu_* outputs, wb_* outputs, frm, fflags and the timeout counter cleared to 0. Reset mid-operation abandons the instruction with no writeback; fpu_start is low from the reset edge onward.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - in_ready=1.
  - On in_valid: latch instr, operands and the frm snapshot; go to ISSUE.
- ISSUE (exactly one cycle):
  - Effective rm = (func3==111) ? frm_snapshot : func3.
  - Rounding-mode ops are opcode 1000011/1000111/1001011/1001111, or opcode 1010011 with func7 in {0000000, 0000100, 0001000, 0001100, 0101100, 1100000, 1101000}.
  - Illegal case: a rounding-mode op with effective rm in {101,110,111}. Go to WB with wb_illegal=1, wb_rd_we=0, wb_data=0. fpu_start is not asserted.
  - Otherwise: fpu_start=1 for this cycle only; go to WAIT; timeout counter cleared.
- WAIT:
  - fpu_* fields stay stable and fpu_start=0.
  - On fpu_done: capture fpu_result/fpu_fflags; go to WB.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without done: wb_data=32'h7FC00000, flags=NV (5'b10000), wb_timeout=1; go to WB.
  - A fpu_done in the same cycle as the timeout wins (normal completion).
- WB:
  - wb_valid=1; all wb_* outputs are held until wb_ready.
  - On wb_valid&wb_ready: fflags |= captured flags (skipped when wb_illegal); go to IDLE.
  - in_ready stays low during WB, so minimum issue interval is accept → next accept = FPU latency + 3 cycles.
- Latency: accept at cycle T, fpu_start at T+1, done at D ≥ T+2, wb_valid at D+1.
- CSR writes:
  - Write to 0x001 sets fflags = wdata[4:0].
  - Write to 0x002 sets frm = wdata[2:0].
  - Write to 0x003 sets both fields from wdata[7:0].
  - When a CSR write to fflags or fcsr coincides with a WB accumulation, the result is wdata[4:0] | captured flags.
  - frm writes affect only instructions accepted later (snapshot rule).
- fpu_done seen outside WAIT is ignored.

Test Plan:
- FADD.S: in_instr 0x003100D3 (func3=000, rd=1), a=0x3F800000, b=0x40000000; FPU answers done 3 cycles after start with 0x40400000, flags 0. Required: exactly one fpu_start cycle; wb_valid with wb_data=0x40400000, wb_rd=1, wb_to_int=0; fflags stays 0.
- Dynamic rm: write frm=3'b101 via csr addr 0x002, then issue FMUL.S with func3=111. Required: no fpu_start; wb_illegal=1, wb_rd_we=0; fflags unchanged. Repeat with frm=001: fpu_frm=001 and fpu_start pulses.
- Flag accrual: two FDIV.S, FPU returns flags 01000 then 00001. Required: csr_rdata@0x001 reads 0x08, then 0x09. Also a CSR write of 0 to 0x001 in the second WB-accept cycle must read 0x01.
- Backpressure: hold wb_ready=0 for 5 cycles. Required: wb_* stable; in_ready=0; a second in_valid is not accepted until one cycle after the handshake.
- Timeout: FPU never asserts done. Required: wb_valid after TIMEOUT_CYCLES WAIT cycles with wb_data=0x7FC00000, wb_timeout=1; fflags NV set.
- Reset in WAIT: assert rst_n=0 two cycles after start. Required: busy=0, wb_valid=0 and fcsr=0 immediately; a late fpu_done produces no writeback.
